// File: rtl/mem_stage_ctrl_if.sv
// Signal bundle between the MEM-stage sequencer and its surroundings
// (EX_MEM outputs, data-memory port, MEM_WB inputs, status).
interface mem_stage_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             MemRead;
  logic             MemWrite;
  logic             Regwrite;
  logic             MemtoReg;
  logic [63:0]      Address;
  logic [63:0]      Write_Data;
  logic             mem_req;
  logic             mem_we;
  logic [63:0]      mem_addr;
  logic [63:0]      mem_wdata;
  logic             mem_ack;
  logic [63:0]      mem_rdata;
  logic             stall;
  logic             Regwrite_wb;
  logic             MemtoReg_wb;
  logic [63:0]      Read_Data_wb;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cycles;

  // Handshake: mem_req is held high from issue until the cycle mem_ack is
  // seen (or the timeout fires); mem_ack is a one-cycle pulse that counts
  // only while a request is outstanding, and mem_rdata is valid with it.
  modport master (
    input  MemRead, MemWrite, Regwrite, MemtoReg, Address, Write_Data,
    input  mem_ack, mem_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output stall, Regwrite_wb, MemtoReg_wb, Read_Data_wb, mem_err, stall_cycles
  );

  modport slave (
    output MemRead, MemWrite, Regwrite, MemtoReg, Address, Write_Data,
    output mem_ack, mem_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  stall, Regwrite_wb, MemtoReg_wb, Read_Data_wb, mem_err, stall_cycles
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM-stage sequencer for a variable-latency data memory: issues one request
// per load/store, stalls upstream and bubbles MEM_WB until the access ends.
module mem_stage_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_stage_ctrl_if.master      bus,
  output logic [1:0]            fsm_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

  state_t       state, state_nx;
  logic [TW-1:0] cnt;
  logic [63:0]  rdata_q;
  logic         op;

  assign op        = bus.MemRead | bus.MemWrite;
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      bus.mem_req      <= 1'b0;
      bus.mem_we       <= 1'b0;
      bus.mem_addr     <= '0;
      bus.mem_wdata    <= '0;
      rdata_q          <= '0;
      cnt              <= '0;
      bus.mem_err      <= 1'b0;
      bus.stall_cycles <= '0;
    end else begin
      state <= state_nx;
      if (bus.stall) bus.stall_cycles <= bus.stall_cycles + CNT_W'(1);
      case (state)
        IDLE: begin
          if (op) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= bus.MemWrite;
            bus.mem_addr  <= bus.Address;
            bus.mem_wdata <= bus.Write_Data;
            cnt           <= '0;
          end
        end
        BUSY: begin
          // An ack arriving on the final timeout cycle still counts as success.
          if (bus.mem_ack) begin
            rdata_q     <= bus.mem_we ? 64'd0 : bus.mem_rdata;
            bus.mem_req <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            bus.mem_err <= 1'b1;
            rdata_q     <= '0;
            bus.mem_req <= 1'b0;
          end else begin
            cnt <= cnt + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx         = state;
    bus.stall        = 1'b0;
    bus.Regwrite_wb  = bus.Regwrite;
    bus.MemtoReg_wb  = bus.MemtoReg;
    bus.Read_Data_wb = '0;
    case (state)
      IDLE: begin
        if (op) begin
          bus.stall       = 1'b1;
          bus.Regwrite_wb = 1'b0;
          bus.MemtoReg_wb = 1'b0;
          state_nx        = BUSY;
        end
      end
      BUSY: begin
        bus.stall       = 1'b1;
        bus.Regwrite_wb = 1'b0;
        bus.MemtoReg_wb = 1'b0;
        if (bus.mem_ack || cnt == CNT_LAST) state_nx = DONE;
      end
      DONE: begin
        bus.Read_Data_wb = rdata_q;
        state_nx         = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: a driver issues EX_MEM ops, a memory
// responder acks after a chosen delay, and a monitor checks each retirement.
module tb_mem_stage_ctrl;
  localparam int CNT_W   = 32;
  localparam int TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] fsm_state;

  mem_stage_ctrl_if #(.CNT_W(CNT_W)) mifc ();

  mem_stage_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (mifc.master),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [65:0] exp_q[$];
  logic        ex_valid = 1'b0;

  // memory responder state
  int          resp_delay = 0;
  int          busy_n = 0;
  logic [63:0] resp_rdata = '0;
  logic        resp_ack = 1'b0;
  logic        stray_ack = 1'b0;
  logic [63:0] stray_rdata = '0;

  assign mifc.mem_ack   = resp_ack | stray_ack;
  assign mifc.mem_rdata = stray_ack ? stray_rdata : (resp_ack ? resp_rdata : 64'd0);

  always @(posedge clk) begin
    #1;
    if (reset || !mifc.mem_req) begin
      busy_n   = 0;
      resp_ack = 1'b0;
    end else begin
      busy_n   = busy_n + 1;
      resp_ack = (resp_delay != 0) && (busy_n == resp_delay);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: an instruction in EX_MEM retires on every cycle without stall.
  always @(negedge clk) begin
    if (!reset && ex_valid && !mifc.stall) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wb_unexpected: got rw=%0b m2r=%0b rd=0x%0h expected no retirement",
                 mifc.Regwrite_wb, mifc.MemtoReg_wb, mifc.Read_Data_wb);
      end else begin
        logic [65:0] e;
        e = exp_q.pop_front();
        if ({mifc.Regwrite_wb, mifc.MemtoReg_wb, mifc.Read_Data_wb} !== e) begin
          n_fail++;
          $display("FAIL wb_out: got rw=%0b m2r=%0b rd=0x%0h expected rw=%0b m2r=%0b rd=0x%0h",
                   mifc.Regwrite_wb, mifc.MemtoReg_wb, mifc.Read_Data_wb,
                   e[65], e[64], e[63:0]);
        end
      end
    end
  end

  task automatic drive_idle();
    @(posedge clk); #1;
    mifc.MemRead = 1'b0; mifc.MemWrite = 1'b0;
    mifc.Regwrite = 1'b0; mifc.MemtoReg = 1'b0;
    mifc.Address = '0; mifc.Write_Data = '0;
    ex_valid = 1'b0; resp_delay = 0;
  endtask

  task automatic run_op(input logic rd, input logic wr, input logic rw, input logic m2r,
                        input logic [63:0] addr, input logic [63:0] wd,
                        input int delay, input logic [63:0] rdata,
                        input logic [63:0] exp_rd, input int exp_stall,
                        input logic [CNT_W-1:0] exp_sc);
    int n_stall;
    int n_req;
    bit done;
    @(posedge clk); #1;
    mifc.MemRead = rd; mifc.MemWrite = wr;
    mifc.Regwrite = rw; mifc.MemtoReg = m2r;
    mifc.Address = addr; mifc.Write_Data = wd;
    ex_valid = 1'b1; resp_delay = delay; resp_rdata = rdata;
    exp_q.push_back({rw, m2r, exp_rd});
    n_stall = 0; n_req = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (mifc.mem_req) begin
        n_req++;
        check("mem_we", {63'd0, mifc.mem_we}, {63'd0, wr});
        check("mem_addr", mifc.mem_addr, addr);
        check("mem_wdata", mifc.mem_wdata, wd);
        // request fields must come from the registers, not the live inputs
        mifc.Address = ~addr; mifc.Write_Data = ~wd;
      end
      if (mifc.stall) n_stall++;
      else done = 1'b1;
    end
    if (!done) check("retire_timeout", 64'd0, 64'd1);
    check("stall_len", 64'(n_stall), 64'(exp_stall));
    check("req_len", 64'(n_req), (exp_stall > 0) ? 64'(exp_stall - 1) : 64'd0);
    check("stall_cycles", 64'(mifc.stall_cycles), 64'(exp_sc));
  endtask

  task automatic stray_pulse(input logic [63:0] d);
    @(posedge clk); #1;
    stray_ack = 1'b1; stray_rdata = d;
    @(posedge clk); #1;
    stray_ack = 1'b0; stray_rdata = '0;
    @(negedge clk);
    check("stray_state", 64'(fsm_state), 64'd0);
    check("stray_req", {63'd0, mifc.mem_req}, 64'd0);
    check("stray_stall", {63'd0, mifc.stall}, 64'd0);
  endtask

  initial begin
    mifc.MemRead = 1'b0; mifc.MemWrite = 1'b0;
    mifc.Regwrite = 1'b0; mifc.MemtoReg = 1'b0;
    mifc.Address = '0; mifc.Write_Data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_state", 64'(fsm_state), 64'd0);
    check("rst_req", {63'd0, mifc.mem_req}, 64'd0);
    check("rst_err", {63'd0, mifc.mem_err}, 64'd0);
    check("rst_sc", 64'(mifc.stall_cycles), 64'd0);
    check("rst_addr", mifc.mem_addr, 64'd0);

    // load acked in third BUSY cycle
    run_op(1, 0, 1, 1, 64'h100, 64'h0, 3, 64'hDEADBEEF, 64'hDEADBEEF, 4, 4);
    drive_idle();
    // store: read data must be zero even though memory returns junk
    run_op(0, 1, 0, 0, 64'h8, 64'h55, 1, 64'hFFFF, 64'h0, 2, 6);
    drive_idle();
    // ack on the last timeout cycle wins
    run_op(1, 0, 1, 1, 64'h40, 64'h0, 4, 64'hCAFE, 64'hCAFE, 5, 11);
    check("err_after_late_ack", {63'd0, mifc.mem_err}, 64'd0);
    drive_idle();
    // back-to-back loads
    run_op(1, 0, 1, 1, 64'h200, 64'h0, 1, 64'h1111, 64'h1111, 2, 13);
    run_op(1, 0, 1, 1, 64'h208, 64'h0, 1, 64'h2222, 64'h2222, 2, 15);
    drive_idle();
    stray_pulse(64'h1234);
    // plain ALU op passes straight through
    run_op(0, 0, 1, 0, 64'h0, 64'h0, 0, 64'h0, 64'h0, 0, 15);
    drive_idle();
    // timeout with no ack
    run_op(1, 0, 1, 1, 64'h300, 64'h0, 0, 64'h0, 64'h0, 5, 20);
    check("err_after_timeout", {63'd0, mifc.mem_err}, 64'd1);
    drive_idle();
    // both MemRead and MemWrite: treated as a store
    run_op(1, 1, 1, 0, 64'h310, 64'hAB, 1, 64'hBAD, 64'h0, 2, 22);
    drive_idle();
    run_op(1, 0, 1, 1, 64'h318, 64'h0, 2, 64'h77, 64'h77, 3, 25);
    check("err_sticky", {63'd0, mifc.mem_err}, 64'd1);
    drive_idle();

    // reset while BUSY
    @(posedge clk); #1;
    mifc.MemRead = 1'b1; mifc.Address = 64'h400;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_req", {63'd0, mifc.mem_req}, 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    mifc.MemRead = 1'b0; mifc.Address = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_state", 64'(fsm_state), 64'd0);
    check("midrst_req", {63'd0, mifc.mem_req}, 64'd0);
    check("midrst_sc", 64'(mifc.stall_cycles), 64'd0);
    check("midrst_err", {63'd0, mifc.mem_err}, 64'd0);
    stray_pulse(64'h999);
    check("late_ack_sc", 64'(mifc.stall_cycles), 64'd0);

    repeat (2) @(posedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Sequences the MEM stage when data memory has variable latency. It sits between the EX_MEM register outputs and the MEM_WB register inputs.
- Issues a req/ack transaction to data memory for each load or store and stalls the upstream pipeline until the access completes.
- Injects bubbles (Regwrite=0, MemtoReg=0) into MEM_WB while waiting, then presents the captured load data for one write-back cycle.
- A timeout counter guards against a hung memory.

Parameters:
- TIMEOUT, 16, max cycles in BUSY without mem_ack before forced completion (>=2)
- CNT_W, 32, width of the stall-cycle performance counter

Ports:
- clk  in  1  system clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- MemRead  in  1  load request from EX_MEM
- MemWrite  in  1  store request from EX_MEM
- Regwrite  in  1  WB control from EX_MEM
- MemtoReg  in  1  WB control from EX_MEM
- Address  in  64  memory address (EX_MEM ALU result)
- Write_Data  in  64  store data
- mem_req  out  1  registered request to data memory
- mem_we  out  1  registered write enable (1 = store)
- mem_addr  out  64  registered address
- mem_wdata  out  64  registered store data
- mem_ack  in  1  memory completion, 1-cycle pulse
- mem_rdata  in  64  load data, valid with mem_ack
- stall  out  1  freeze PC, IF_ID, ID_EX, EX_MEM (combinational)
- Regwrite_wb  out  1  Regwrite to MEM_WB, gated
- MemtoReg_wb  out  1  MemtoReg to MEM_WB, gated
- Read_Data_wb  out  64  read data to MEM_WB
- mem_err  out  1  sticky timeout flag
- stall_cycles  out  CNT_W  count of cycles with stall=1

Behaviour:
- Reset (sync, active-high; overrides everything):
  - state=IDLE.
  - mem_req, mem_we, mem_addr, mem_wdata, rdata_q, timeout counter, mem_err and stall_cycles all = 0.
- States: IDLE, BUSY, DONE.
- op = MemRead | MemWrite. If both are set, treat as a store: mem_we=1, and the captured data is 0.
- IDLE:
  - No op: stall=0, Regwrite_wb=Regwrite, MemtoReg_wb=MemtoReg, Read_Data_wb=0.
  - op: stall=1, Regwrite_wb=0, MemtoReg_wb=0.
  - On op, next state=BUSY. Registers set: mem_req=1, mem_we=MemWrite, mem_addr=Address, mem_wdata=Write_Data, counter=0.
- BUSY:
  - stall=1; Regwrite_wb=0 and MemtoReg_wb=0 (bubble); mem_req stays 1.
  - Address and data are held from the registers and do not track inputs.
  - mem_ack=1: capture rdata_q=mem_rdata (0 for a store), mem_req=0, next state=DONE.
  - Otherwise, when counter==TIMEOUT-1: mem_err=1, rdata_q=0, mem_req=0, next state=DONE.
  - Otherwise counter increments.
  - ack and timeout in the same cycle: ack wins and mem_err is unchanged.
- DONE (exactly one cycle):
  - stall=0, Regwrite_wb=Regwrite, MemtoReg_wb=MemtoReg, Read_Data_wb=rdata_q.
  - MEM_WB captures at the end of this cycle and EX_MEM advances.
  - Next state=IDLE.
- Latency:
  - An op first seen in cycle T with ack in T+1 gives stall in T and T+1; write-back data is captured at the end of T+2.
  - Each extra ack delay adds one stall cycle.
- Back-to-back ops: the new op is seen in IDLE in the cycle after DONE. There is no request overlap.
- mem_ack outside BUSY is ignored; there is no state change and rdata_q does not change.
- mem_err clears only on reset.
- stall_cycles increments on every cycle with stall=1 and wraps modulo 2^CNT_W.
- Reset during BUSY: next cycle is IDLE with mem_req=0. A late ack is ignored.

Test Plan:
- Load: Address=0x100, MemRead=1, Regwrite=1, MemtoReg=1; ack after 3 BUSY cycles with rdata=0xDEADBEEF → stall high 4 cycles; Regwrite_wb=0 during stall; DONE shows Read_Data_wb=0xDEADBEEF, Regwrite_wb=1; stall_cycles=4.
- Store: MemWrite=1, Address=0x8, Write_Data=0x55 → mem_we=1, mem_addr=0x8, mem_wdata=0x55 held through BUSY; ack → DONE with Read_Data_wb=0.
- Timeout: TIMEOUT=4, no ack → mem_req drops after 4 BUSY cycles; mem_err=1, Read_Data_wb=0 in DONE; later op still completes normally and mem_err stays 1.
- Ack coinciding with the last timeout cycle → mem_err stays 0 and the data is captured.
- Two consecutive loads, each acked after 1 cycle → two DONE cycles separated by IDLE+BUSY; a stray ack in IDLE changes nothing.
- Non-memory ALU op (Regwrite=1) → stall=0, pass-through with zero latency; reset asserted mid-BUSY → IDLE, mem_req=0, counters 0, a subsequent ack is ignored.
